// File: rtl/uart_core_param.sv
`default_nettype none
// ============================================================================
//  Module      : uart_core_param
//  Description : Single-clock UART with a shared clock-enable baud tick.
//                TX takes words over a valid/ready handshake. RX oversamples
//                the line, samples each bit at its middle, and reports parity
//                and framing errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_core_param #(
    parameter int CLK_FREQ   = 1000000,
    parameter int BAUDRATE   = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ready,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_parity_err,
    output logic                  rx_frame_err
);

    localparam int c_div_raw = CLK_FREQ / (BAUDRATE * OVERSAMPLE);
    localparam int c_div     = (c_div_raw < 1) ? 1 : c_div_raw;
    localparam int c_div_w   = (c_div > 1) ? $clog2(c_div) : 1;
    localparam int c_os_w    = $clog2(OVERSAMPLE);
    localparam int c_bit_w   = $clog2(DATA_WIDTH);

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(c_div - 1);
    localparam logic [c_os_w-1:0]  c_os_last  = c_os_w'(OVERSAMPLE - 1);
    localparam logic [c_os_w-1:0]  c_os_half  = c_os_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(DATA_WIDTH - 1);
    localparam logic               c_stop_last = (STOP_BITS == 2);
    localparam logic               c_par_odd   = (PARITY_ODD != 0);
    localparam logic               c_par_en    = (PARITY_EN != 0);

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_start  = 3'd1;
    localparam logic [2:0] c_data   = 3'd2;
    localparam logic [2:0] c_parity = 3'd3;
    localparam logic [2:0] c_stop   = 3'd4;

    // ------------------------------------------------------------------
    // Baud tick generator
    // ------------------------------------------------------------------
    logic [c_div_w-1:0] div_cnt_q, div_cnt_d;
    logic               w_tick;

    // One tick every c_div clocks; with c_div=1 the tick is always on.
    always_comb begin
        w_tick    = (div_cnt_q == c_div_last);
        div_cnt_d = w_tick ? '0 : div_cnt_q + 1'b1;
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    logic [2:0]            tx_state_q, tx_state_d;
    logic [c_os_w-1:0]     tx_cnt_q, tx_cnt_d;
    logic [c_bit_w-1:0]    tx_bit_q, tx_bit_d;
    logic                  tx_stop_q, tx_stop_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_par_q, tx_par_d;
    logic                  tx_done_q, tx_done_d;
    logic                  w_tx_bit_end;

    // TX next state: each bit lasts OVERSAMPLE ticks; parity is fixed at accept.
    always_comb begin
        tx_state_d   = tx_state_q;
        tx_cnt_d     = tx_cnt_q;
        tx_bit_d     = tx_bit_q;
        tx_stop_d    = tx_stop_q;
        tx_data_d    = tx_data_q;
        tx_par_d     = tx_par_q;
        tx_done_d    = 1'b0;
        w_tx_bit_end = w_tick && (tx_cnt_q == c_os_last);
        if (tx_state_q != c_idle && w_tick) begin
            tx_cnt_d = w_tx_bit_end ? '0 : tx_cnt_q + 1'b1;
        end
        case (tx_state_q)
            c_idle: begin
                if (tx_valid) begin
                    tx_data_d  = tx_data;
                    tx_par_d   = (^tx_data) ^ c_par_odd;
                    tx_state_d = c_start;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_stop_d  = 1'b0;
                end
            end
            c_start: if (w_tx_bit_end) tx_state_d = c_data;
            c_data: begin
                if (w_tx_bit_end) begin
                    if (tx_bit_q == c_bit_last) tx_state_d = c_par_en ? c_parity : c_stop;
                    else                        tx_bit_d   = tx_bit_q + 1'b1;
                end
            end
            c_parity: if (w_tx_bit_end) tx_state_d = c_stop;
            c_stop: begin
                if (w_tx_bit_end) begin
                    if (tx_stop_q == c_stop_last) begin
                        tx_state_d = c_idle;
                        tx_done_d  = 1'b1;
                    end else begin
                        tx_stop_d = 1'b1;
                    end
                end
            end
            default: tx_state_d = c_idle;
        endcase
    end

    // TX outputs decoded from state so reset forces the line high at once.
    always_comb begin
        tx_ready = (tx_state_q == c_idle);
        tx_busy  = (tx_state_q != c_idle);
        tx_done  = tx_done_q;
        case (tx_state_q)
            c_start:  tx = 1'b0;
            c_data:   tx = tx_data_q[tx_bit_q];
            c_parity: tx = tx_par_q;
            default:  tx = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic                  sync1_q, sync1_d, sync2_q, sync2_d;
    logic [2:0]            rx_state_q, rx_state_d;
    logic [c_os_w-1:0]     rx_cnt_q, rx_cnt_d;
    logic [c_bit_w-1:0]    rx_bit_q, rx_bit_d;
    logic                  rx_stop_q, rx_stop_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic                  rx_perr_q, rx_perr_d;
    logic                  rx_ferr_q, rx_ferr_d;
    logic                  rx_armed_q, rx_armed_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rx_parity_err_q, rx_parity_err_d;
    logic                  rx_frame_err_q, rx_frame_err_d;
    logic                  w_rx_s, w_rx_sample;

    // RX next state: half-bit wait confirms the start, then one sample per bit.
    always_comb begin
        sync1_d         = rx;
        sync2_d         = sync1_q;
        w_rx_s          = sync2_q;
        rx_state_d      = rx_state_q;
        rx_cnt_d        = rx_cnt_q;
        rx_bit_d        = rx_bit_q;
        rx_stop_d       = rx_stop_q;
        rx_shift_d      = rx_shift_q;
        rx_perr_d       = rx_perr_q;
        rx_ferr_d       = rx_ferr_q;
        rx_armed_d      = rx_armed_q;
        rx_data_d       = rx_data_q;
        rx_valid_d      = 1'b0;
        rx_parity_err_d = rx_parity_err_q;
        rx_frame_err_d  = rx_frame_err_q;
        w_rx_sample     = w_tick && (rx_cnt_q == ((rx_state_q == c_start) ? c_os_half : c_os_last));
        if (rx_state_q != c_idle && w_tick) begin
            rx_cnt_d = w_rx_sample ? '0 : rx_cnt_q + 1'b1;
        end
        case (rx_state_q)
            c_idle: begin
                // Re-arm only once the line has been seen high (break handling).
                if (w_rx_s) rx_armed_d = 1'b1;
                if (w_tick && rx_armed_q && !w_rx_s) begin
                    rx_state_d = c_start;
                    rx_cnt_d   = '0;
                end
            end
            c_start: begin
                if (w_rx_sample) begin
                    if (w_rx_s) begin
                        rx_state_d = c_idle;
                    end else begin
                        rx_state_d = c_data;
                        rx_bit_d   = '0;
                        rx_stop_d  = 1'b0;
                        rx_perr_d  = 1'b0;
                        rx_ferr_d  = 1'b0;
                    end
                end
            end
            c_data: begin
                if (w_rx_sample) begin
                    rx_shift_d = {w_rx_s, rx_shift_q[DATA_WIDTH-1:1]};
                    if (rx_bit_q == c_bit_last) rx_state_d = c_par_en ? c_parity : c_stop;
                    else                        rx_bit_d   = rx_bit_q + 1'b1;
                end
            end
            c_parity: begin
                if (w_rx_sample) begin
                    rx_perr_d  = ((^rx_shift_q) ^ c_par_odd) != w_rx_s;
                    rx_state_d = c_stop;
                end
            end
            c_stop: begin
                if (w_rx_sample) begin
                    if (!w_rx_s) rx_ferr_d = 1'b1;
                    if (rx_stop_q == c_stop_last) begin
                        rx_valid_d      = 1'b1;
                        rx_data_d       = rx_shift_q;
                        rx_parity_err_d = rx_perr_q;
                        rx_frame_err_d  = rx_ferr_q | !w_rx_s;
                        rx_state_d      = c_idle;
                        rx_armed_d      = 1'b0;
                    end else begin
                        rx_stop_d = 1'b1;
                    end
                end
            end
            default: rx_state_d = c_idle;
        endcase
    end

    // RX outputs are straight from their registers.
    always_comb begin
        rx_data       = rx_data_q;
        rx_valid      = rx_valid_q;
        rx_parity_err = rx_parity_err_q;
        rx_frame_err  = rx_frame_err_q;
    end

    // State registers for tick generator, TX and RX.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_q       <= '0;
            tx_state_q      <= c_idle;
            tx_cnt_q        <= '0;
            tx_bit_q        <= '0;
            tx_stop_q       <= 1'b0;
            tx_data_q       <= '0;
            tx_par_q        <= 1'b0;
            tx_done_q       <= 1'b0;
            sync1_q         <= 1'b1;
            sync2_q         <= 1'b1;
            rx_state_q      <= c_idle;
            rx_cnt_q        <= '0;
            rx_bit_q        <= '0;
            rx_stop_q       <= 1'b0;
            rx_shift_q      <= '0;
            rx_perr_q       <= 1'b0;
            rx_ferr_q       <= 1'b0;
            rx_armed_q      <= 1'b0;
            rx_data_q       <= '0;
            rx_valid_q      <= 1'b0;
            rx_parity_err_q <= 1'b0;
            rx_frame_err_q  <= 1'b0;
        end else begin
            div_cnt_q       <= div_cnt_d;
            tx_state_q      <= tx_state_d;
            tx_cnt_q        <= tx_cnt_d;
            tx_bit_q        <= tx_bit_d;
            tx_stop_q       <= tx_stop_d;
            tx_data_q       <= tx_data_d;
            tx_par_q        <= tx_par_d;
            tx_done_q       <= tx_done_d;
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            rx_state_q      <= rx_state_d;
            rx_cnt_q        <= rx_cnt_d;
            rx_bit_q        <= rx_bit_d;
            rx_stop_q       <= rx_stop_d;
            rx_shift_q      <= rx_shift_d;
            rx_perr_q       <= rx_perr_d;
            rx_ferr_q       <= rx_ferr_d;
            rx_armed_q      <= rx_armed_d;
            rx_data_q       <= rx_data_d;
            rx_valid_q      <= rx_valid_d;
            rx_parity_err_q <= rx_parity_err_d;
            rx_frame_err_q  <= rx_frame_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_core_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_core_param
//  Description : Bench for uart_core_param: 8N1, 8E2 and 8O1 instances with
//                tx looped to rx or a bench-driven line; scoreboard queues.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_core_param;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic lb = 1'b1;
    logic drv_rx = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   n;
    int   n1_done_cyc = 0;
    rec_t g, e;
    rec_t exp_n1[$], got_n1[$], exp_e2[$], got_e2[$], exp_o1[$], got_o1[$];

    logic       n1_tx_valid = 1'b0, e2_tx_valid = 1'b0, o1_tx_valid = 1'b0;
    logic [7:0] n1_tx_data = '0, e2_tx_data = '0, o1_tx_data = '0;
    logic       n1_tx_ready, n1_tx, n1_tx_busy, n1_tx_done, n1_rx_valid, n1_rx_perr, n1_rx_ferr;
    logic       e2_tx_ready, e2_tx, e2_tx_busy, e2_tx_done, e2_rx_valid, e2_rx_perr, e2_rx_ferr;
    logic       o1_tx_ready, o1_tx, o1_tx_busy, o1_tx_done, o1_rx_valid, o1_rx_perr, o1_rx_ferr;
    logic [7:0] n1_rx_data, e2_rx_data, o1_rx_data;
    logic       n1_rx, e2_rx, o1_rx;

    assign n1_rx = lb ? n1_tx : drv_rx;
    assign e2_rx = lb ? e2_tx : drv_rx;
    assign o1_rx = lb ? o1_tx : drv_rx;

    uart_core_param #(.CLK_FREQ(1600000), .BAUDRATE(100000), .OVERSAMPLE(16), .DATA_WIDTH(8),
                      .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_n1 (
        .clk(clk), .reset(rst_n), .tx_valid(n1_tx_valid), .tx_data(n1_tx_data),
        .tx_ready(n1_tx_ready), .tx(n1_tx), .tx_busy(n1_tx_busy), .tx_done(n1_tx_done),
        .rx(n1_rx), .rx_data(n1_rx_data), .rx_valid(n1_rx_valid),
        .rx_parity_err(n1_rx_perr), .rx_frame_err(n1_rx_ferr));

    uart_core_param #(.CLK_FREQ(1600000), .BAUDRATE(100000), .OVERSAMPLE(16), .DATA_WIDTH(8),
                      .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_e2 (
        .clk(clk), .reset(rst_n), .tx_valid(e2_tx_valid), .tx_data(e2_tx_data),
        .tx_ready(e2_tx_ready), .tx(e2_tx), .tx_busy(e2_tx_busy), .tx_done(e2_tx_done),
        .rx(e2_rx), .rx_data(e2_rx_data), .rx_valid(e2_rx_valid),
        .rx_parity_err(e2_rx_perr), .rx_frame_err(e2_rx_ferr));

    uart_core_param #(.CLK_FREQ(1600000), .BAUDRATE(100000), .OVERSAMPLE(16), .DATA_WIDTH(8),
                      .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_o1 (
        .clk(clk), .reset(rst_n), .tx_valid(o1_tx_valid), .tx_data(o1_tx_data),
        .tx_ready(o1_tx_ready), .tx(o1_tx), .tx_busy(o1_tx_busy), .tx_done(o1_tx_done),
        .rx(o1_rx), .rx_data(o1_rx_data), .rx_valid(o1_rx_valid),
        .rx_parity_err(o1_rx_perr), .rx_frame_err(o1_rx_ferr));

    always #5 clk = ~clk;

    // Cycle counter used to time accept and done events.
    always @(posedge clk) cyc <= cyc + 1;

    // Capture every received frame and the TX done time of the 8N1 instance.
    always @(negedge clk) begin
        if (n1_rx_valid) got_n1.push_back({n1_rx_data, n1_rx_perr, n1_rx_ferr});
        if (e2_rx_valid) got_e2.push_back({e2_rx_data, e2_rx_perr, e2_rx_ferr});
        if (o1_rx_valid) got_o1.push_back({o1_rx_data, o1_rx_perr, o1_rx_ferr});
        if (n1_tx_done) n1_done_cyc = cyc;
    end

    task automatic clear_queues();
        exp_n1.delete(); got_n1.delete();
        exp_e2.delete(); got_e2.delete();
        exp_o1.delete(); got_o1.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({n1_tx, n1_tx_ready, n1_tx_busy, n1_tx_done, n1_rx_valid, n1_rx_perr, n1_rx_ferr, n1_rx_data} !== 15'b1100000_00000000) begin
            errors++;
            $display("FAIL reset_state got tx=%b rdy=%b busy=%b done=%b rxv=%b pe=%b fe=%b d=%h exp 1 1 0 0 0 0 0 00",
                     n1_tx, n1_tx_ready, n1_tx_busy, n1_tx_done, n1_rx_valid, n1_rx_perr, n1_rx_ferr, n1_rx_data);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_8n1();
        int   a;
        logic [9:0] line;
        clear_queues();
        lb = 1'b1;
        line = {1'b1, 8'hA5, 1'b0};
        @(negedge clk);
        n1_tx_valid = 1'b1; n1_tx_data = 8'hA5;
        exp_n1.push_back({8'hA5, 1'b0, 1'b0});
        @(negedge clk);
        n1_tx_valid = 1'b0; a = cyc;
        checks++;
        if (n1_tx_ready !== 1'b0 || n1_tx_busy !== 1'b1) begin
            errors++; $display("FAIL 8n1_accept got rdy=%b busy=%b exp 0 1", n1_tx_ready, n1_tx_busy);
        end
        repeat (8) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (n1_tx !== line[k]) begin
                errors++; $display("FAIL 8n1_line bit%0d got %b exp %b", k, n1_tx, line[k]);
            end
            repeat (16) @(negedge clk);
        end
        n = 0;
        while (got_n1.size() < 1 && n < 400) begin @(negedge clk); n++; end
        checks++;
        if (n1_done_cyc - a < 159 || n1_done_cyc - a > 161) begin
            errors++; $display("FAIL 8n1_done_latency got %0d exp 160", n1_done_cyc - a);
        end
        checks++;
        if (got_n1.size() < 1) begin
            errors++; $display("FAIL 8n1_rx_timeout got %0d frames exp 1", got_n1.size());
        end else begin
            g = got_n1.pop_front(); e = exp_n1.pop_front();
            if (g !== e) begin
                errors++; $display("FAIL 8n1_rx got d=%h pe=%b fe=%b exp d=%h pe=%b fe=%b", g.d, g.pe, g.fe, e.d, e.pe, e.fe);
            end
        end
    endtask

    task automatic test_parity();
        logic [11:0] fr;
        clear_queues();
        lb = 1'b1;
        @(negedge clk);
        e2_tx_valid = 1'b1; e2_tx_data = 8'h07;
        o1_tx_valid = 1'b1; o1_tx_data = 8'h07;
        exp_e2.push_back({8'h07, 1'b0, 1'b0});
        exp_o1.push_back({8'h07, 1'b0, 1'b0});
        @(negedge clk);
        e2_tx_valid = 1'b0; o1_tx_valid = 1'b0;
        repeat (8 + 9 * 16) @(negedge clk);
        checks++;
        if (e2_tx !== 1'b1 || o1_tx !== 1'b0) begin
            errors++; $display("FAIL parity_bit got even=%b odd=%b exp 1 0", e2_tx, o1_tx);
        end
        repeat (32) @(negedge clk);
        checks++;
        if (e2_tx !== 1'b1 || e2_tx_busy !== 1'b1) begin
            errors++; $display("FAIL e2_second_stop got tx=%b busy=%b exp 1 1", e2_tx, e2_tx_busy);
        end
        n = 0;
        while ((got_e2.size() < 1 || got_o1.size() < 1) && n < 400) begin @(negedge clk); n++; end
        checks++;
        if (got_e2.size() < 1 || got_o1.size() < 1) begin
            errors++; $display("FAIL parity_rx_timeout got e2=%0d o1=%0d exp 1 1", got_e2.size(), got_o1.size());
        end else begin
            g = got_e2.pop_front(); e = exp_e2.pop_front();
            if (g !== e) begin
                errors++; $display("FAIL e2_loop_rx got d=%h pe=%b fe=%b exp d=%h pe=%b fe=%b", g.d, g.pe, g.fe, e.d, e.pe, e.fe);
            end
            g = got_o1.pop_front(); e = exp_o1.pop_front();
            if (g !== e) begin
                errors++; $display("FAIL o1_loop_rx got d=%h pe=%b fe=%b exp d=%h pe=%b fe=%b", g.d, g.pe, g.fe, e.d, e.pe, e.fe);
            end
        end
        // Bench-driven 8E2 frame with the parity bit forced to 0.
        repeat (32) @(negedge clk);
        clear_queues();
        lb = 1'b0;
        fr = {2'b11, 1'b0, 8'h07, 1'b0};
        exp_e2.push_back({8'h07, 1'b1, 1'b0});
        exp_o1.push_back({8'h07, 1'b0, 1'b0});
        exp_n1.push_back({8'h07, 1'b0, 1'b1});
        for (int k = 0; k < 12; k++) begin drv_rx = fr[k]; repeat (16) @(negedge clk); end
        drv_rx = 1'b1;
        n = 0;
        while ((got_e2.size() < 1 || got_o1.size() < 1 || got_n1.size() < 1) && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (got_e2.size() < 1) begin
            errors++; $display("FAIL e2_bad_parity_timeout got 0 frames exp 1");
        end else begin
            g = got_e2.pop_front(); e = exp_e2.pop_front();
            if (g !== e) begin
                errors++; $display("FAIL e2_bad_parity got d=%h pe=%b fe=%b exp d=%h pe=%b fe=%b", g.d, g.pe, g.fe, e.d, e.pe, e.fe);
            end
        end
        checks++;
        if (got_o1.size() < 1 || got_n1.size() < 1) begin
            errors++; $display("FAIL cross_rx_timeout got o1=%0d n1=%0d exp 1 1", got_o1.size(), got_n1.size());
        end else begin
            g = got_o1.pop_front(); e = exp_o1.pop_front();
            if (g !== e) begin
                errors++; $display("FAIL o1_cross got d=%h pe=%b fe=%b exp d=%h pe=%b fe=%b", g.d, g.pe, g.fe, e.d, e.pe, e.fe);
            end
            g = got_n1.pop_front(); e = exp_n1.pop_front();
            if (g !== e) begin
                errors++; $display("FAIL n1_cross got d=%h pe=%b fe=%b exp d=%h pe=%b fe=%b", g.d, g.pe, g.fe, e.d, e.pe, e.fe);
            end
        end
    endtask

    task automatic test_framing();
        logic [9:0] fr;
        clear_queues();
        lb = 1'b0;
        fr = {1'b0, 8'h3C, 1'b0};
        exp_n1.push_back({8'h3C, 1'b0, 1'b1});
        for (int k = 0; k < 10; k++) begin drv_rx = fr[k]; repeat (16) @(negedge clk); end
        drv_rx = 1'b1;
        repeat (32) @(negedge clk);
        checks++;
        if (got_n1.size() != 1) begin
            errors++; $display("FAIL frame_err_count got %0d frames exp 1", got_n1.size());
        end else begin
            g = got_n1.pop_front(); e = exp_n1.pop_front();
            if (g !== e) begin
                errors++; $display("FAIL frame_err got d=%h pe=%b fe=%b exp d=%h pe=%b fe=%b", g.d, g.pe, g.fe, e.d, e.pe, e.fe);
            end
        end
        // Break: 20 bit-times low gives exactly one errored frame.
        clear_queues();
        exp_n1.push_back({8'h00, 1'b0, 1'b1});
        drv_rx = 1'b0;
        repeat (20 * 16) @(negedge clk);
        checks++;
        if (got_n1.size() != 1) begin
            errors++; $display("FAIL break_count got %0d frames exp 1", got_n1.size());
        end else begin
            g = got_n1.pop_front(); e = exp_n1.pop_front();
            if (g !== e) begin
                errors++; $display("FAIL break_rx got d=%h pe=%b fe=%b exp d=%h pe=%b fe=%b", g.d, g.pe, g.fe, e.d, e.pe, e.fe);
            end
        end
        drv_rx = 1'b1;
        repeat (48) @(negedge clk);
        checks++;
        if (got_n1.size() != 0) begin
            errors++; $display("FAIL break_release got %0d extra frames exp 0", got_n1.size());
        end
    endtask

    task automatic test_false_start();
        logic [9:0] fr;
        clear_queues();
        lb = 1'b0;
        drv_rx = 1'b0;
        repeat (4) @(negedge clk);
        drv_rx = 1'b1;
        repeat (32) @(negedge clk);
        checks++;
        if (got_n1.size() != 0 || u_n1.rx_state_q !== 3'd0) begin
            errors++; $display("FAIL false_start got frames=%0d state=%0d exp 0 0", got_n1.size(), u_n1.rx_state_q);
        end
        fr = {1'b1, 8'h5A, 1'b0};
        exp_n1.push_back({8'h5A, 1'b0, 1'b0});
        for (int k = 0; k < 10; k++) begin drv_rx = fr[k]; repeat (16) @(negedge clk); end
        drv_rx = 1'b1;
        repeat (16) @(negedge clk);
        checks++;
        if (got_n1.size() != 1) begin
            errors++; $display("FAIL after_glitch_count got %0d frames exp 1", got_n1.size());
        end else begin
            g = got_n1.pop_front(); e = exp_n1.pop_front();
            if (g !== e) begin
                errors++; $display("FAIL after_glitch_rx got d=%h pe=%b fe=%b exp d=%h pe=%b fe=%b", g.d, g.pe, g.fe, e.d, e.pe, e.fe);
            end
        end
    endtask

    task automatic test_back_to_back();
        int low_cnt;
        clear_queues();
        lb = 1'b1;
        exp_n1.push_back({8'h11, 1'b0, 1'b0});
        exp_n1.push_back({8'h22, 1'b0, 1'b0});
        @(negedge clk);
        n1_tx_valid = 1'b1; n1_tx_data = 8'h11;
        @(negedge clk);
        n1_tx_data = 8'h22;
        for (int f = 0; f < 2; f++) begin
            low_cnt = 0; n = 0;
            while (n1_tx_done !== 1'b1 && n < 400) begin
                if (n1_tx_ready === 1'b0) low_cnt++;
                @(negedge clk); n++;
            end
            checks++;
            if (low_cnt != 160 || n1_tx_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_ready_low frame%0d got %0d clks rdy_at_done=%b exp 160 1", f, low_cnt, n1_tx_ready);
            end
            @(negedge clk);
            if (f == 0) begin
                checks++;
                if (n1_tx !== 1'b0 || n1_tx_ready !== 1'b0) begin
                    errors++; $display("FAIL b2b_second_start got tx=%b rdy=%b exp 0 0", n1_tx, n1_tx_ready);
                end
                n1_tx_valid = 1'b0;
            end
        end
        n = 0;
        while (got_n1.size() < 2 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (got_n1.size() != 2) begin
            errors++; $display("FAIL b2b_rx_count got %0d frames exp 2", got_n1.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                g = got_n1.pop_front(); e = exp_n1.pop_front();
                if (g !== e) begin
                    errors++; $display("FAIL b2b_rx%0d got d=%h pe=%b fe=%b exp d=%h pe=%b fe=%b", k, g.d, g.pe, g.fe, e.d, e.pe, e.fe);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_queues();
        lb = 1'b1;
        @(negedge clk);
        n1_tx_valid = 1'b1; n1_tx_data = 8'h96;
        @(negedge clk);
        n1_tx_valid = 1'b0;
        repeat (70) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (n1_tx !== 1'b1 || n1_tx_ready !== 1'b1 || n1_tx_busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid_tx got tx=%b rdy=%b busy=%b exp 1 1 0", n1_tx, n1_tx_ready, n1_tx_busy);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        checks++;
        if (got_n1.size() != 0) begin
            errors++; $display("FAIL reset_mid_rx got %0d frames exp 0", got_n1.size());
        end
        exp_n1.push_back({8'hC3, 1'b0, 1'b0});
        n1_tx_valid = 1'b1; n1_tx_data = 8'hC3;
        @(negedge clk);
        n1_tx_valid = 1'b0;
        n = 0;
        while (got_n1.size() < 1 && n < 400) begin @(negedge clk); n++; end
        checks++;
        if (got_n1.size() < 1) begin
            errors++; $display("FAIL post_reset_timeout got 0 frames exp 1");
        end else begin
            g = got_n1.pop_front(); e = exp_n1.pop_front();
            if (g !== e) begin
                errors++; $display("FAIL post_reset_rx got d=%h pe=%b fe=%b exp d=%h pe=%b fe=%b", g.d, g.pe, g.fe, e.d, e.pe, e.fe);
            end
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_framing();
        test_false_start();
        test_back_to_back();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
Parametrised single-clock-domain UART. It replaces the derived-uclk transmitter/receiver pair with clock-enable baud ticks on the system clock. Width, parity and stop-bit count are configurable. TX uses a valid/ready handshake. RX oversamples, samples at mid-bit, and reports parity and framing errors. It sits between the bus-side register block and the serial pins.

Parameters:
CLK_FREQ, 1000000, system clock frequency in Hz
BAUDRATE, 9600, serial bit rate
OVERSAMPLE, 16, RX ticks per bit; even, >=4
DATA_WIDTH, 8, payload bits per frame, 5..9
PARITY_EN, 0, 1 = append/check one parity bit after data
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)
STOP_BITS, 1, stop bits per frame, 1 or 2

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  asynchronous, active-low reset
tx_valid  in  1  TX word offered
tx_data  in  DATA_WIDTH  TX payload, LSB first on line
tx_ready  out  1  TX can accept a word
tx  out  1  serial output, idle high
tx_busy  out  1  frame in progress
tx_done  out  1  one-clk pulse at end of last stop bit
rx  in  1  serial input, asynchronous
rx_data  out  DATA_WIDTH  last received payload; held until next rx_valid
rx_valid  out  1  one-clk pulse, rx_data updated
rx_parity_err  out  1  valid with rx_valid; 0 if PARITY_EN=0
rx_frame_err  out  1  valid with rx_valid; a stop bit sampled low

Behaviour:
- Reset (reset=0, async): tx=1, tx_ready=1, tx_busy=0, tx_done=0, rx_data=0, rx_valid=0, both error flags 0, both FSMs IDLE, all counters 0. The RX synchroniser resets to 1.
- Tick generator: DIV = CLK_FREQ/(BAUDRATE*OVERSAMPLE), integer division, minimum 1. A free-running counter asserts tick for one clk every DIV clks. TX and RX share it.
- TX FSM: IDLE -> START -> DATA -> PARITY (only if PARITY_EN) -> STOP -> IDLE. Each state/bit lasts OVERSAMPLE ticks.
- TX acceptance: a word is accepted on a clk where tx_valid & tx_ready. tx_data is latched, tx_ready drops, tx_busy rises. The START state begins and tx=0 on the next clk.
- tx_ready=1 only in IDLE. tx_valid while not ready is ignored; the word is held by the source.
- TX data is sent LSB first. Parity = XOR of the payload, inverted if PARITY_ODD. Stop bits are tx=1 for STOP_BITS bit-times.
- TX end of frame: tx_done pulses on the clk the final stop bit ends. The same clk returns to IDLE (tx_ready=1), so back-to-back accept happens no earlier than the next clk.
- Frame length: 1+DATA_WIDTH+PARITY_EN+STOP_BITS bit-times, each OVERSAMPLE*DIV clks, ±1 DIV for tick phase at accept.
- RX input: rx passes through a 2-flop synchroniser; all RX logic uses the synchronised value.
- RX FSM: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE.
- RX IDLE: a low level on a tick enters START and clears the tick counter.
- RX START: after OVERSAMPLE/2 ticks, line re-sampled. If high, it is a false start: return to IDLE with no rx_valid. If low, proceed.
- RX subsequent samples: every OVERSAMPLE ticks, i.e. mid-bit. Data bits shift in LSB first.
- RX STOP: each of STOP_BITS is sampled. Any low sample sets frame_err. rx_valid pulses when the last stop sample is taken, then the FSM returns to IDLE and waits for the line to be high before arming again.
- RX outputs at rx_valid: rx_data, rx_parity_err and rx_frame_err are updated together with the pulse. An errored frame still updates rx_data.
- RX break: a line held low, including stop, gives rx_valid with rx_data=0 and frame_err=1. There is no re-arm until rx is seen high.
- Independence: TX and RX are fully independent; simultaneous activity is allowed.
- Reset mid-frame: TX aborts and tx returns to 1 immediately. A partial RX frame is discarded and no rx_valid is produced.

Test Plan:
Setup for all scenarios: CLK_FREQ=1600000, BAUDRATE=100000, OVERSAMPLE=16, so DIV=1 and a bit lasts 16 clks. Loop tx to rx.
- 8N1 loopback: send 8'hA5 -> tx line shows 0,1,0,1,0,0,1,0,1,1 at 16 clk/bit; rx_valid with rx_data=8'hA5, errors 0. tx_done occurs 160 clks after accept (±1).
- 8E2 and 8O1 parity: PARITY_EN=1 and send 8'h07 -> even parity bit=1, odd parity bit=0. Bench-corrupted parity gives rx_parity_err=1 with rx_data=8'h07.
- Framing/break: bench drives a 8'h3C frame with the stop bit low -> rx_frame_err=1, rx_data=8'h3C. Holding rx=0 for 20 bit-times gives exactly one rx_valid (data 0, frame_err 1) until rx returns high.
- False start: 4-clk low glitch on an idle rx -> no rx_valid, FSM back in IDLE, and a following valid 8'h5A frame is received correctly.
- Back-to-back TX: tx_valid held high with 8'h11 then 8'h22 -> tx_ready low for each full frame. The second start bit begins within 2 clks of the first tx_done, and both bytes are received in order.
- Async reset mid-frame: reset=0 during TX bit 3 and RX bit 4 -> tx=1 and tx_ready=1 immediately, no rx_valid. The next full frame after release is received correctly.
